// File: rtl/dma_axi_write_master_if.sv
// AXI4 write-channel bundle (AW, W, B) between the DMA write master and the
// memory-side slave. Signal names keep their original M_AXI_* spelling.
interface dma_axi_write_master_if #(
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
);
    // Write address channel
    logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_AWID;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR;
    logic [7:0]                      M_AXI_AWLEN;
    logic [2:0]                      M_AXI_AWSIZE;
    logic [1:0]                      M_AXI_AWBURST;
    logic                            M_AXI_AWLOCK;
    logic [3:0]                      M_AXI_AWCACHE;
    logic [2:0]                      M_AXI_AWPROT;
    logic [3:0]                      M_AXI_AWQOS;
    logic [0:0]                      M_AXI_AWUSER;
    logic                            M_AXI_AWVALID;
    logic                            M_AXI_AWREADY;
    // Write data channel
    logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA;
    logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB;
    logic                            M_AXI_WLAST;
    logic [0:0]                      M_AXI_WUSER;
    logic                            M_AXI_WVALID;
    logic                            M_AXI_WREADY;
    // Write response channel
    logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_BID;
    logic [1:0]                      M_AXI_BRESP;
    logic [0:0]                      M_AXI_BUSER;
    logic                            M_AXI_BVALID;
    logic                            M_AXI_BREADY;

    modport master (
        output M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
               M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWUSER,
               M_AXI_AWVALID,
               M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WUSER, M_AXI_WVALID,
               M_AXI_BREADY,
        input  M_AXI_AWREADY, M_AXI_WREADY,
               M_AXI_BID, M_AXI_BRESP, M_AXI_BUSER, M_AXI_BVALID
    );

    modport slave (
        input  M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
               M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWUSER,
               M_AXI_AWVALID,
               M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WUSER, M_AXI_WVALID,
               M_AXI_BREADY,
        output M_AXI_AWREADY, M_AXI_WREADY,
               M_AXI_BID, M_AXI_BRESP, M_AXI_BUSER, M_AXI_BVALID
    );
endinterface

// File: rtl/dma_axi_write_master.sv
// DMA write master: pulls words from a standard-mode FIFO through a 2-entry
// holding buffer and writes them to memory as AXI4 INCR bursts, one burst
// outstanding at a time.
// Optional feature macro: DMA_WR_4K_SPLIT_EN -- when defined, bursts are cut
// so that none crosses a 4KB address boundary.
module dma_axi_write_master #(
    parameter int C_M_AXI_BURST_LEN  = 16,
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic        M_AXI_ACLK,
    input  logic        M_AXI_ARESETN,
    input  logic        i_start,
    input  logic [31:0] i_dst_addr,
    input  logic [31:0] i_total_len,
    input  logic [31:0] i_w_data,
    input  logic        i_fifo_empty,
    output logic        o_fifo_rd_en,
    output logic        o_write_done,
    output logic        o_write_error,
    dma_axi_write_master_if.master m_axi
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        start_q;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  awlen_q, awlen_d;
    logic [29:0] left_q, left_d;      // words not yet completed, current burst included
    logic [29:0] wcnt_q, wcnt_d;      // word count of the whole transfer
    logic [29:0] popped_q, popped_d;  // FIFO pops issued for this transfer
    logic [7:0]  beat_q, beat_d;      // W handshakes in the current burst
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [31:0] buf0_q, buf0_d;      // buffer head
    logic [31:0] buf1_q, buf1_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic        infl_q;              // a pop was issued last cycle, data arrives now

    logic        start_rise;
    logic        w_hs;
    logic [8:0]  cur_beats;
    logic [31:0] adv_addr;
    logic [29:0] adv_left;
    logic [31:0] nb_addr;
    logic [29:0] nb_words;
    logic [29:0] nb_lim;
    logic [8:0]  nb_beats;
`ifdef DMA_WR_4K_SPLIT_EN
    logic [10:0] page_words;
`endif
    logic        unused_ok;

    assign start_rise = i_start & ~start_q;
    assign w_hs       = m_axi.M_AXI_WVALID & m_axi.M_AXI_WREADY;
    assign cur_beats  = {1'b0, awlen_q} + 9'd1;
    assign adv_addr   = addr_q + {21'b0, cur_beats, 2'b00};
    assign adv_left   = left_q - {21'b0, cur_beats};
    assign unused_ok  = ^{m_axi.M_AXI_BID, m_axi.M_AXI_BUSER, i_total_len[1:0]};

    // Beat count of the next burst: from the start inputs when idle, otherwise
    // from the position just past the burst currently being acknowledged.
    always_comb begin
        nb_addr  = adv_addr;
        nb_words = adv_left;
        if (state_q == ST_IDLE || state_q == ST_DONE) begin
            nb_addr  = i_dst_addr;
            nb_words = i_total_len[31:2];
        end
        nb_lim = 30'(C_M_AXI_BURST_LEN);
        if (nb_words < nb_lim) nb_lim = nb_words;
`ifdef DMA_WR_4K_SPLIT_EN
        page_words = 11'((13'd4096 - {1'b0, nb_addr[11:0]}) >> 2);
        if ({19'b0, page_words} < nb_lim) nb_lim = {19'b0, page_words};
`endif
        nb_beats = 9'(nb_lim);
    end

    // FIFO pop: keep buffered plus in-flight words at most 2, never overrun the count.
    always_comb begin
        o_fifo_rd_en = 1'b0;
        if ((state_q == ST_ADDR || state_q == ST_DATA || state_q == ST_RESP) &&
            !i_fifo_empty && (({1'b0, bcnt_q} + {2'b0, infl_q}) < 3'd2) &&
            (popped_q < wcnt_q))
            o_fifo_rd_en = 1'b1;
    end

    // Transfer FSM next-state and burst bookkeeping.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        awlen_d  = awlen_q;
        left_d   = left_q;
        wcnt_d   = wcnt_q;
        popped_d = popped_q + {29'b0, o_fifo_rd_en};
        beat_d   = beat_q;
        done_d   = done_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_rise) begin
                    addr_d   = i_dst_addr;
                    wcnt_d   = i_total_len[31:2];
                    left_d   = i_total_len[31:2];
                    popped_d = '0;
                    err_d    = 1'b0;
                    if (i_total_len[31:2] == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ADDR;
                        done_d  = 1'b0;
                        awlen_d = 8'(nb_beats - 9'd1);
                    end
                end
            end
            ST_ADDR: begin
                if (m_axi.M_AXI_AWREADY) begin
                    state_d = ST_DATA;
                    beat_d  = '0;
                end
            end
            ST_DATA: begin
                if (w_hs) begin
                    beat_d = beat_q + 8'd1;
                    if (beat_q == awlen_q) state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (m_axi.M_AXI_BVALID) begin
                    if (m_axi.M_AXI_BRESP != 2'b00) err_d = 1'b1;
                    left_d = adv_left;
                    if (adv_left != '0) begin
                        addr_d  = adv_addr;
                        awlen_d = 8'(nb_beats - 9'd1);
                        state_d = ST_ADDR;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Holding buffer: simultaneous arrival and W handshake shift and refill in one cycle.
    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        bcnt_d = bcnt_q;
        if (infl_q && w_hs) begin
            if (bcnt_q == 2'd1) begin
                buf0_d = i_w_data;
            end else begin
                buf0_d = buf1_q;
                buf1_d = i_w_data;
            end
        end else if (infl_q) begin
            if (bcnt_q == 2'd0) buf0_d = i_w_data;
            else                buf1_d = i_w_data;
            bcnt_d = bcnt_q + 2'd1;
        end else if (w_hs) begin
            buf0_d = buf1_q;
            bcnt_d = bcnt_q - 2'd1;
        end
    end

    // State, counters and buffer registers with synchronous active-low reset.
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state_q  <= ST_IDLE;
            start_q  <= 1'b0;
            addr_q   <= '0;
            awlen_q  <= '0;
            left_q   <= '0;
            wcnt_q   <= '0;
            popped_q <= '0;
            beat_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            buf0_q   <= '0;
            buf1_q   <= '0;
            bcnt_q   <= '0;
            infl_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= i_start;
            addr_q   <= addr_d;
            awlen_q  <= awlen_d;
            left_q   <= left_d;
            wcnt_q   <= wcnt_d;
            popped_q <= popped_d;
            beat_q   <= beat_d;
            done_q   <= done_d;
            err_q    <= err_d;
            buf0_q   <= buf0_d;
            buf1_q   <= buf1_d;
            bcnt_q   <= bcnt_d;
            infl_q   <= o_fifo_rd_en;
        end
    end

    assign o_write_done  = done_q;
    assign o_write_error = err_q;

    assign m_axi.M_AXI_AWID    = C_M_AXI_ID_WIDTH'(0);
    assign m_axi.M_AXI_AWADDR  = C_M_AXI_ADDR_WIDTH'(addr_q);
    assign m_axi.M_AXI_AWLEN   = awlen_q;
    assign m_axi.M_AXI_AWSIZE  = 3'b010;
    assign m_axi.M_AXI_AWBURST = 2'b01;
    assign m_axi.M_AXI_AWLOCK  = 1'b0;
    assign m_axi.M_AXI_AWCACHE = 4'b0010;
    assign m_axi.M_AXI_AWPROT  = 3'b000;
    assign m_axi.M_AXI_AWQOS   = 4'b0000;
    assign m_axi.M_AXI_AWUSER  = '0;
    assign m_axi.M_AXI_AWVALID = (state_q == ST_ADDR);

    assign m_axi.M_AXI_WDATA   = C_M_AXI_DATA_WIDTH'(buf0_q);
    assign m_axi.M_AXI_WSTRB   = '1;
    assign m_axi.M_AXI_WUSER   = '0;
    assign m_axi.M_AXI_WVALID  = (state_q == ST_DATA) && (bcnt_q != 2'd0);
    assign m_axi.M_AXI_WLAST   = m_axi.M_AXI_WVALID && (beat_q == awlen_q);

    assign m_axi.M_AXI_BREADY  = (state_q == ST_RESP);

endmodule

// File: tb/tb_dma_axi_write_master.sv
// Bench for dma_axi_write_master: randomized FIFO contents and ready/empty
// patterns, checked against a burst-list / word-order reference model.
module tb_dma_axi_write_master;

    localparam int BL = 16;

    logic        clk;
    logic        rstn;
    logic        i_start;
    logic [31:0] i_dst_addr;
    logic [31:0] i_total_len;
    logic [31:0] i_w_data;
    logic        i_fifo_empty;
    logic        o_fifo_rd_en;
    logic        o_write_done;
    logic        o_write_error;

    dma_axi_write_master_if #(
        .C_M_AXI_ID_WIDTH(1), .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32)
    ) ifc ();

    dma_axi_write_master #(
        .C_M_AXI_BURST_LEN(BL), .C_M_AXI_ID_WIDTH(1),
        .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rstn), .i_start(i_start),
        .i_dst_addr(i_dst_addr), .i_total_len(i_total_len), .i_w_data(i_w_data),
        .i_fifo_empty(i_fifo_empty), .o_fifo_rd_en(o_fifo_rd_en),
        .o_write_done(o_write_done), .o_write_error(o_write_error), .m_axi(ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] fifo_q[$];
    logic [31:0] exp_words[$];
    logic [31:0] w_obs[$];
    logic [31:0] aw_addr_obs[$];
    int          aw_len_obs[$];
    logic [31:0] exp_aw_addr[$];
    int          exp_aw_len[$];

    bit pend_pop, present, burst_active, aw_wait, mon_en;
    bit rand_aw, rand_w, toggle_empty, err_first;
    int delivered, whs, pops, b_count, last_b_cyc, cur_len, beat_in_burst, awv_seen;
    int cur_wc, cur_extra;
    bit cur_ef;
    logic [31:0] aw_wait_addr;
    logic [7:0]  aw_wait_len;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: FIFO/slave responses at the falling edge, then sample and record.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (present) delivered++;
        present = 1'b0;
        if (pend_pop) begin
            if (fifo_q.size() > 0) i_w_data = fifo_q.pop_front();
            else i_w_data = 32'hDEAD_BEEF;
            present  = 1'b1;
            pend_pop = 1'b0;
        end
        i_fifo_empty = (fifo_q.size() == 0) || (toggle_empty && (((cyc / 3) % 2) == 1));
        ifc.M_AXI_AWREADY = rand_aw ? 1'($urandom_range(0, 1)) : 1'b1;
        ifc.M_AXI_WREADY  = rand_w  ? 1'($urandom_range(0, 1)) : 1'b1;
        ifc.M_AXI_BVALID  = 1'b1;
        ifc.M_AXI_BRESP   = (err_first && b_count == 0) ? 2'b10 : 2'b00;
        #1;
        if (mon_en) begin
            if (aw_wait)
                check("aw_hold", {ifc.M_AXI_AWVALID, ifc.M_AXI_AWADDR, ifc.M_AXI_AWLEN},
                      {1'b1, aw_wait_addr, aw_wait_len});
            aw_wait      = ifc.M_AXI_AWVALID && !ifc.M_AXI_AWREADY;
            aw_wait_addr = ifc.M_AXI_AWADDR;
            aw_wait_len  = ifc.M_AXI_AWLEN;
            check("wvalid", ifc.M_AXI_WVALID, burst_active && ((delivered - whs) > 0));
            if (ifc.M_AXI_WVALID && ifc.M_AXI_WREADY) begin
                check("wlast", ifc.M_AXI_WLAST, beat_in_burst == cur_len);
                w_obs.push_back(ifc.M_AXI_WDATA);
                whs++;
                beat_in_burst++;
                if (beat_in_burst > cur_len) burst_active = 1'b0;
            end
            if (ifc.M_AXI_AWVALID) awv_seen++;
            if (ifc.M_AXI_AWVALID && ifc.M_AXI_AWREADY) begin
                aw_addr_obs.push_back(ifc.M_AXI_AWADDR);
                aw_len_obs.push_back(int'(ifc.M_AXI_AWLEN));
                burst_active  = 1'b1;
                cur_len       = int'(ifc.M_AXI_AWLEN);
                beat_in_burst = 0;
            end
            if (ifc.M_AXI_BVALID && ifc.M_AXI_BREADY) begin
                b_count++;
                last_b_cyc = cyc;
            end
            if (o_fifo_rd_en) begin
                check("rd_when_empty", i_fifo_empty, 1'b0);
                pops++;
                pend_pop = 1'b1;
            end
        end
    endtask

    // Fill the FIFO, build the expected burst list, and pulse start.
    task automatic prep_xfer(input logic [31:0] dst, input logic [31:0] len, input bit rw,
                             input bit ra, input bit te, input bit ef, input int extra);
        longint unsigned a;
        int w, b;
        fifo_q.delete(); exp_words.delete(); w_obs.delete();
        aw_addr_obs.delete(); aw_len_obs.delete(); exp_aw_addr.delete(); exp_aw_len.delete();
        pend_pop = 0; present = 0; burst_active = 0; aw_wait = 0;
        delivered = 0; whs = 0; pops = 0; b_count = 0; last_b_cyc = -10; awv_seen = 0;
        cur_len = 0; beat_in_burst = 0;
        cur_wc = int'(len >> 2); cur_extra = extra; cur_ef = ef;
        for (int i = 0; i < cur_wc + extra; i++) begin
            logic [31:0] d;
            d = $urandom;
            fifo_q.push_back(d);
            if (i < cur_wc) exp_words.push_back(d);
        end
        a = longint'(dst);
        w = cur_wc;
        while (w > 0) begin
            b = (w < BL) ? w : BL;
`ifdef DMA_WR_4K_SPLIT_EN
            if (int'((4096 - (a % 4096)) / 4) < b) b = int'((4096 - (a % 4096)) / 4);
`endif
            exp_aw_addr.push_back(32'(a));
            exp_aw_len.push_back(b - 1);
            a = a + longint'(4 * b);
            w = w - b;
        end
        rand_w = rw; rand_aw = ra; toggle_empty = te; err_first = ef;
        i_dst_addr = dst;
        i_total_len = len;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        if (cur_wc != 0) begin
            check("done_clear", o_write_done, 1'b0);
            check("err_clear", o_write_error, 1'b0);
        end
    endtask

    // Wait for completion and compare against the model.
    task automatic finish_xfer(input bit restart_mid);
        int n;
        n = 0;
        while (!o_write_done && n < 3000) begin
            if (restart_mid && n == 5) i_start = 1'b1;
            if (restart_mid && n == 7) i_start = 1'b0;
            tick();
            n++;
        end
        i_start = 1'b0;
        check("done_timeout", o_write_done, 1'b1);
        if (cur_wc == 0) begin
            check("zero_done_lat", n, 0);
            check("zero_awvalid", awv_seen, 0);
        end else begin
            check("done_latency", cyc, last_b_cyc + 1);
        end
        check("aw_count", aw_addr_obs.size(), exp_aw_addr.size());
        for (int i = 0; i < aw_addr_obs.size() && i < exp_aw_addr.size(); i++) begin
            check("aw_addr", aw_addr_obs[i], exp_aw_addr[i]);
            check("aw_len", aw_len_obs[i], exp_aw_len[i]);
        end
        check("beats", whs, cur_wc);
        for (int i = 0; i < w_obs.size() && i < exp_words.size(); i++)
            check("wdata", w_obs[i], exp_words[i]);
        check("pops", pops, cur_wc);
        check("fifo_left", fifo_q.size(), cur_extra);
        check("b_count", b_count, exp_aw_addr.size());
        check("error_flag", o_write_error, cur_ef);
        tick();
        check("done_sticky", o_write_done, 1'b1);
    endtask

    task automatic check_reset_outputs();
        check("rst_awvalid", ifc.M_AXI_AWVALID, 1'b0);
        check("rst_wvalid", ifc.M_AXI_WVALID, 1'b0);
        check("rst_wlast", ifc.M_AXI_WLAST, 1'b0);
        check("rst_bready", ifc.M_AXI_BREADY, 1'b0);
        check("rst_rd_en", o_fifo_rd_en, 1'b0);
        check("rst_done", o_write_done, 1'b0);
        check("rst_error", o_write_error, 1'b0);
        check("rst_awaddr", ifc.M_AXI_AWADDR, 32'h0);
        check("rst_awlen", ifc.M_AXI_AWLEN, 8'h0);
    endtask

    initial begin
        logic [31:0] rdst, rlen;
        int rwc, roff, n;
        rstn = 1'b0; i_start = 1'b0; i_dst_addr = '0; i_total_len = '0;
        i_w_data = '0; i_fifo_empty = 1'b1; mon_en = 1'b0;
        ifc.M_AXI_AWREADY = 1'b0; ifc.M_AXI_WREADY = 1'b0; ifc.M_AXI_BVALID = 1'b0;
        ifc.M_AXI_BRESP = 2'b00; ifc.M_AXI_BID = '0; ifc.M_AXI_BUSER = '0;
        rand_aw = 0; rand_w = 0; toggle_empty = 0; err_first = 0;
        pend_pop = 0; present = 0; b_count = 0;
        repeat (3) tick();
        check_reset_outputs();
        check("constants",
              {ifc.M_AXI_AWID, ifc.M_AXI_AWSIZE, ifc.M_AXI_AWBURST, ifc.M_AXI_AWLOCK,
               ifc.M_AXI_AWCACHE, ifc.M_AXI_AWPROT, ifc.M_AXI_AWQOS, ifc.M_AXI_AWUSER,
               ifc.M_AXI_WSTRB, ifc.M_AXI_WUSER},
              {1'b0, 3'b010, 2'b01, 1'b0, 4'b0010, 3'b000, 4'b0000, 1'b0, 4'hF, 1'b0});
        rstn = 1'b1;
        tick();
        mon_en = 1'b1;

        // Single burst
        prep_xfer(32'h4000_0000, 32'd64, 0, 0, 0, 0, 3);
        finish_xfer(0);
        // Two bursts, second one partial
        prep_xfer(32'h4000_0000, 32'd100, 0, 0, 0, 0, 2);
        finish_xfer(0);
        // Start just below a 4KB boundary
        prep_xfer(32'h4000_0FF0, 32'd64, 0, 0, 0, 0, 1);
        finish_xfer(0);
        // Backpressure on every side, plus a start edge that must be ignored
        prep_xfer(32'h4000_2000, 32'd64, 1, 1, 1, 0, 4);
        finish_xfer(1);
        // Error response on the first of two bursts
        prep_xfer(32'h4000_3000, 32'd128, 0, 0, 0, 1, 0);
        finish_xfer(0);
        // Zero length
        prep_xfer(32'h4000_4000, 32'd0, 0, 0, 0, 0, 2);
        finish_xfer(0);
        // Random transfers, low length bits set to check they are ignored
        for (int t = 0; t < 4; t++) begin
            rwc  = $urandom_range(1, 70);
            roff = $urandom_range(0, 1024 - rwc);
`ifdef DMA_WR_4K_SPLIT_EN
            roff = $urandom_range(0, 1023);
`endif
            rdst = 32'h2000_0000 + 32'(t * 4096) + 32'(roff * 4);
            rlen = 32'(rwc * 4) + 32'($urandom_range(0, 3));
            prep_xfer(rdst, rlen, 1, 1, ($urandom_range(0, 1) == 1), 0, $urandom_range(0, 3));
            finish_xfer(0);
        end

        // Reset during beat 5, then a normal transfer
        prep_xfer(32'h4000_5000, 32'd64, 0, 0, 0, 0, 0);
        n = 0;
        while (whs < 4 && n < 500) begin
            tick();
            n++;
        end
        check("reach_beat5", whs, 4);
        rstn = 1'b0;
        mon_en = 1'b0;
        tick();
        check_reset_outputs();
        rstn = 1'b1;
        tick();
        mon_en = 1'b1;
        prep_xfer(32'h4000_6000, 32'd16, 0, 0, 0, 0, 2);
        finish_xfer(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_axi_write_master.md
DMA_AXI_WRITE_MASTER -- requirements
Module: dma_axi_write_master

Interface
REQ-001 SHALL have parameter C_M_AXI_BURST_LEN, default 16, meaning max beats per burst (1..256).
REQ-002 SHALL have parameter C_M_AXI_ID_WIDTH, default 1, meaning AWID/BID width.
REQ-003 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, meaning AWADDR width.
REQ-004 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, meaning W data width (32 only).
REQ-005 SHALL have port M_AXI_ACLK, input, 1 bit: the single clock. All logic runs on its rising edge.
REQ-006 SHALL have port M_AXI_ARESETN, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port i_start, input, 1 bit: transfer start request. Only a rising edge is acted on.
REQ-008 SHALL have port i_dst_addr, input, 32 bits: destination byte address, word aligned.
REQ-009 SHALL have port i_total_len, input, 32 bits: transfer length in bytes, a multiple of 4.
REQ-010 SHALL have port i_w_data, input, 32 bits: FIFO dout, valid 1 cycle after o_fifo_rd_en (standard-mode FIFO).
REQ-011 SHALL have port i_fifo_empty, input, 1 bit: FIFO empty flag.
REQ-012 SHALL have port o_fifo_rd_en, output, 1 bit: FIFO pop.
REQ-013 SHALL have port o_write_done, output, 1 bit: sticky transfer-complete flag.
REQ-014 SHALL have port o_write_error, output, 1 bit: sticky flag, set on any non-OKAY BRESP.
REQ-015 SHALL have ports M_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID (outputs) and M_AXI_AWREADY (input), AXI4 widths, forming the write address channel.
REQ-016 SHALL have ports M_AXI_AWLOCK/AWCACHE/AWPROT/AWQOS/AWUSER, outputs, AXI4 widths, tied constant.
REQ-017 SHALL have ports M_AXI_WDATA/WSTRB/WLAST/WUSER/WVALID (outputs) and M_AXI_WREADY (input), forming the write data channel.
REQ-018 SHALL have ports M_AXI_BID/BRESP/BUSER/BVALID (inputs) and M_AXI_BREADY (output), forming the write response channel.

Function
REQ-019 SHALL implement states IDLE, ADDR, DATA, RESP, DONE.
- IDLE/DONE -> ADDR on a rising edge of i_start; address and length are latched on that edge.
- IDLE/DONE -> DONE when the latched length is 0; no AW is issued in that case.
REQ-020 SHALL compute the word count as i_total_len[31:2]; bits [1:0] SHALL be ignored.
REQ-021 SHALL set the beat count of each burst to min(C_M_AXI_BURST_LEN, remaining words, 4KB limit per REQ-033).
- AWLEN = beats-1.
- AWADDR advances by beats*4 after each burst.
REQ-022 SHALL handle the address channel as follows:
- In ADDR: AWVALID=1, with AWADDR/AWLEN held stable until the AWREADY handshake.
- The state then moves to DATA.
REQ-023 SHALL handle the data channel as follows:
- In DATA: WVALID=1 whenever the holding buffer is non-empty; WDATA = buffer head.
- WLAST=1 on the final beat of the burst.
- After the last handshake, the state moves to RESP.
REQ-024 SHALL handle the response channel as follows:
- In RESP: BREADY=1.
- On BVALID: go to ADDR if words remain, otherwise go to DONE.
- Only one burst is outstanding at a time.
REQ-025 SHALL keep a 2-entry holding buffer fed from the FIFO. o_fifo_rd_en=1 only when all of:
- !i_fifo_empty;
- (buffered + in-flight reads) < 2;
- words popped < word count.
REQ-026 SHALL never pop more words than the word count; FIFO data for a later transfer is untouched.
REQ-027 SHALL accept a pop and a W handshake in the same cycle without loss or duplication.
REQ-028 SHALL set o_write_done 1 cycle after the final B handshake (or after a zero-length start), hold it until the next accepted start, then clear it.
REQ-029 SHALL set o_write_error on BRESP!=2'b00. The transfer SHALL continue. The flag clears on the next accepted start.
REQ-030 SHALL ignore i_start edges in ADDR, DATA and RESP.
REQ-031 SHALL drive constants:
- AWID=0, AWSIZE=3'b010, AWBURST=2'b01, AWLOCK=0, AWCACHE=4'b0010, AWPROT=0, AWQOS=0, AWUSER=0;
- WSTRB=4'hF, WUSER=0.

Reset
REQ-032 SHALL, while M_AXI_ARESETN=0 at a clock edge (including mid-transfer):
- enter IDLE;
- clear counters, the holding buffer and the start-edge detector;
- drive AWVALID/WVALID/WLAST/BREADY/o_fifo_rd_en/o_write_done/o_write_error=0, AWADDR=0, AWLEN=0.

Configuration
REQ-033 SHALL support the macro DMA_WR_4K_SPLIT_EN:
- Defined: the beat count is further limited to (4096-AWADDR[11:0])/4, so no burst crosses a 4KB boundary.
- Undefined: no 4KB limit is applied; the caller guarantees no crossing.

Verification
REQ-034 SHALL cover a single burst:
- Stimulus: dst=0x4000_0000, len=64, FIFO prefilled, AWREADY=WREADY=BVALID=1.
- Response: one AW with AWLEN=15; 16 beats with WLAST on beat 16; o_write_done=1 one cycle after the B handshake.
REQ-035 SHALL cover a multi-burst transfer:
- Stimulus: dst=0x4000_0000, len=100.
- Response: AW 0x4000_0000/AWLEN=15, then AW 0x4000_0040/AWLEN=8; 25 pops in total.
REQ-036 SHALL cover 4KB splitting:
- Stimulus: dst=0x4000_0FF0, len=64.
- With the macro: AW 0x4000_0FF0/AWLEN=3, then 0x4000_1000/AWLEN=11.
- Without the macro: a single AW with AWLEN=15.
REQ-037 SHALL cover backpressure:
- Stimulus: len=64; i_fifo_empty toggles every 3 cycles; WREADY random.
- Response: WDATA sequence equals FIFO order; exactly 16 rd_en pulses; WVALID drops only when the buffer is empty.
REQ-038 SHALL cover error and zero-length cases:
- Stimulus: BRESP=2'b10 on the 1st of 2 bursts.
- Response: o_write_error=1, the 2nd burst is still issued, o_write_done=1.
- Stimulus: len=0.
- Response: no AWVALID, and o_write_done=1.
REQ-039 SHALL cover reset mid-transfer:
- Stimulus: reset asserted during beat 5 of DATA.
- Response: all outputs at reset values the next cycle; a new start with len=16 completes normally.
